// File: rtl/and_gate_pkg.sv
// Shared constants and helpers for the and_gate block.
package and_gate_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;

  // Bits needed to hold a ones count in the range 0..width.
  function automatic int unsigned count_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/and_gate_popcount.sv
// Number of set bits in a WIDTH-bit vector.
module and_gate_popcount
  import and_gate_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]              data,
  output logic [count_width(WIDTH)-1:0] count
);

  localparam int unsigned CW = count_width(WIDTH);

  always_comb begin
    count = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      count = count + CW'(data[i]);
    end
  end

endmodule

// File: rtl/and_gate.sv
// Bitwise AND with a combinational result and a valid-qualified registered copy plus status flags.
module and_gate
  import and_gate_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH-1:0]              X,
  input  logic [WIDTH-1:0]              Y,
  input  logic                          in_valid,
  output logic [WIDTH-1:0]              OUT,
  output logic [WIDTH-1:0]              out_q,
  output logic                          out_valid,
  output logic                          all_ones,
  output logic                          all_zero,
  output logic [count_width(WIDTH)-1:0] ones_count
);

  assign OUT = X & Y;

  // Capture only when qualified; out_valid marks an update on the last edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q <= X & Y;
      end
    end
  end

  // Status flags derive from out_q alone so they track it exactly.
  assign all_ones = &out_q;
  assign all_zero = ~|out_q;

  and_gate_popcount #(
    .WIDTH (WIDTH)
  ) u_popcount (
    .data  (out_q),
    .count (ones_count)
  );

endmodule

// File: tb/tb_and_gate.sv
// Self-checking bench for and_gate at WIDTH 1, 4 and 8.
module tb_and_gate;

  logic clk;
  logic rst_n;

  logic [7:0] x8, y8, out8, q8;
  logic       v8, ov8, ao8, az8;
  logic [3:0] cnt8;

  logic       x1, y1, out1, q1;
  logic       v1, ov1, ao1, az1;
  logic       cnt1;

  logic [3:0] x4, y4, out4, q4;
  logic       v4, ov4, ao4, az4;
  logic [2:0] cnt4;

  int n_checks;
  int n_fail;

  and_gate #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .X(x8), .Y(y8), .in_valid(v8), .OUT(out8),
    .out_q(q8), .out_valid(ov8), .all_ones(ao8), .all_zero(az8), .ones_count(cnt8)
  );

  and_gate #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .X(x1), .Y(y1), .in_valid(v1), .OUT(out1),
    .out_q(q1), .out_valid(ov1), .all_ones(ao1), .all_zero(az1), .ones_count(cnt1)
  );

  and_gate #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .X(x4), .Y(y4), .in_valid(v4), .OUT(out4),
    .out_q(q4), .out_valid(ov4), .all_ones(ao4), .all_zero(az4), .ones_count(cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Full status check of the 8-bit instance against an expected held value.
  task automatic check8(input string tag, input logic [7:0] eq, input logic ev);
    check({tag, " out_q"},      64'(q8),   64'(eq));
    check({tag, " out_valid"},  64'(ov8),  64'(ev));
    check({tag, " ones_count"}, 64'(cnt8), 64'($countones(eq)));
    check({tag, " all_ones"},   64'(ao8),  64'(eq == 8'hFF));
    check({tag, " all_zero"},   64'(az8),  64'(eq == 8'h00));
  endtask

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       v;
    logic [7:0] exp_out;
    logic [7:0] exp_q;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[8];

  logic [7:0] m_q;
  logic       m_v;
  logic [1:0] xy;

  initial begin
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{x: 8'hF0, y: 8'h3C, v: 1'b1, exp_out: 8'h30, exp_q: 8'h30, exp_valid: 1'b1};
    vecs[1] = '{x: 8'hFF, y: 8'hFF, v: 1'b1, exp_out: 8'hFF, exp_q: 8'hFF, exp_valid: 1'b1};
    vecs[2] = '{x: 8'h00, y: 8'h00, v: 1'b0, exp_out: 8'h00, exp_q: 8'hFF, exp_valid: 1'b0};
    vecs[3] = '{x: 8'h12, y: 8'h34, v: 1'b0, exp_out: 8'h10, exp_q: 8'hFF, exp_valid: 1'b0};
    vecs[4] = '{x: 8'hC3, y: 8'hFF, v: 1'b0, exp_out: 8'hC3, exp_q: 8'hFF, exp_valid: 1'b0};
    vecs[5] = '{x: 8'hAA, y: 8'h0F, v: 1'b1, exp_out: 8'h0A, exp_q: 8'h0A, exp_valid: 1'b1};
    vecs[6] = '{x: 8'h00, y: 8'hFF, v: 1'b1, exp_out: 8'h00, exp_q: 8'h00, exp_valid: 1'b1};
    vecs[7] = '{x: 8'h81, y: 8'hC1, v: 1'b1, exp_out: 8'h81, exp_q: 8'h81, exp_valid: 1'b1};

    rst_n = 1'b0;
    x8 = 8'h5A; y8 = 8'hFF; v8 = 1'b1;
    x1 = 1'b0;  y1 = 1'b0;  v1 = 1'b0;
    x4 = 4'h0;  y4 = 4'h0;  v4 = 1'b0;

    // Reset values hold across an edge even with in_valid high.
    #1;
    check8("reset", 8'h00, 1'b0);
    check("reset OUT tracks", 64'(out8), 64'h5A);
    @(posedge clk); #1;
    check8("reset edge", 8'h00, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    v8 = 1'b0;

    // Table-driven vectors on the 8-bit instance.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      x8 = vecs[i].x; y8 = vecs[i].y; v8 = vecs[i].v;
      #1;
      check($sformatf("vec%0d OUT", i), 64'(out8), 64'(vecs[i].exp_out));
      @(posedge clk); #1;
      check8($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_valid);
    end

    // Asynchronous reset between edges after capturing 0x30.
    @(negedge clk);
    x8 = 8'hF0; y8 = 8'h3C; v8 = 1'b1;
    @(posedge clk); #1;
    check8("pre-reset", 8'h30, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check8("async reset", 8'h00, 1'b0);
    check("async reset OUT", 64'(out8), 64'h30);
    x8 = 8'h6E; y8 = 8'h3B;
    #1;
    check("reset OUT follows", 64'(out8), 64'h2A);
    @(negedge clk);
    rst_n = 1'b1;
    x8 = 8'h0F; y8 = 8'hFF; v8 = 1'b1;
    @(posedge clk); #1;
    check8("first capture", 8'h0F, 1'b1);

    // WIDTH=1 truth table at 5-unit spacing.
    for (int i = 0; i < 4; i++) begin
      xy = 2'(i);
      x1 = xy[1]; y1 = xy[0];
      #1;
      check($sformatf("w1 OUT xy=%0d", i), 64'(out1), 64'(i == 3));
      #4;
    end
    @(negedge clk);
    x1 = 1'b1; y1 = 1'b1; v1 = 1'b1;
    @(posedge clk); #1;
    check("w1 out_q",      64'(q1),   64'h1);
    check("w1 all_ones",   64'(ao1),  64'h1);
    check("w1 all_zero",   64'(az1),  64'h0);
    check("w1 ones_count", 64'(cnt1), 64'h1);
    @(negedge clk);
    v1 = 1'b0;

    // WIDTH=4 disjoint operands give zero.
    x4 = 4'hA; y4 = 4'h5; v4 = 1'b1;
    #1;
    check("w4 OUT", 64'(out4), 64'h0);
    @(posedge clk); #1;
    check("w4 out_q",      64'(q4),   64'h0);
    check("w4 out_valid",  64'(ov4),  64'h1);
    check("w4 all_zero",   64'(az4),  64'h1);
    check("w4 all_ones",   64'(ao4),  64'h0);
    check("w4 ones_count", 64'(cnt4), 64'h0);
    @(negedge clk);
    x4 = 4'hF; y4 = 4'hF;
    @(posedge clk); #1;
    check("w4 full ones_count", 64'(cnt4), 64'h4);
    check("w4 full all_ones",   64'(ao4),  64'h1);

    // Randomized run against a value-level model of the registered path.
    m_q = q8;
    m_v = ov8;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      x8 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      y8 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      v8 = ($urandom_range(0, 3) != 0);
      #1;
      check("rand OUT", 64'(out8), 64'(x8 & y8));
      m_v = v8;
      if (v8) m_q = x8 & y8;
      @(posedge clk); #1;
      check8("rand", m_q, m_v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
